// File: rtl/oserdes_ddr.sv
// Parallel-to-DDR serialiser: per lane, it feeds two bits per clock to an external DDR output
// primitive. A one-entry hold register sits in front of a shift register so that words stream
// back to back with no gap.
module oserdes_ddr #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LANES     = 1,
  parameter logic        INIT      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ce,
  input  logic [WIDTH*LANES-1:0]   s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [LANES-1:0]         d0,
  output logic [LANES-1:0]         d1,
  output logic                     active,
  output logic                     underrun,
  output logic [7:0]               underrun_count
);

  localparam int unsigned BEATS = WIDTH / 2;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DW    = WIDTH * LANES;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DW-1:0]     sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LANES-1:0]  d0_q, d0_d, d1_q, d1_d;
  logic              underrun_q, underrun_d;
  logic [7:0]        ucnt_q, ucnt_d;

  logic last_c, load_c, fin_c, accept_c;

  assign last_c   = (cnt_q == LAST_BEAT);
  assign load_c   = ce && hold_full_q && ((state_q == IDLE) || last_c);
  assign fin_c    = ce && (state_q == RUN) && last_c && !hold_full_q;
  assign s_ready  = (!hold_full_q || load_c) && resetn && ce;
  assign accept_c = s_valid && s_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (load_c)     state_d = RUN;
    else if (fin_c) state_d = IDLE;
  end

  // Datapath and output next values; ce low leaves everything at its current value
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    underrun_d  = 1'b0;
    ucnt_d      = ucnt_q;
    if (ce) begin
      underrun_d = fin_c;
      if (fin_c && (ucnt_q != 8'hFF)) ucnt_d = ucnt_q + 8'd1;
      if (load_c) begin
        cnt_d       = '0;
        hold_full_d = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
          if (MSB_FIRST) begin
            d0_d[i]                   = hold_q[i*WIDTH + WIDTH - 1];
            d1_d[i]                   = hold_q[i*WIDTH + WIDTH - 2];
            sr_d[i*WIDTH +: WIDTH]    = hold_q[i*WIDTH +: WIDTH] << 2;
          end else begin
            d0_d[i]                   = hold_q[i*WIDTH];
            d1_d[i]                   = hold_q[i*WIDTH + 1];
            sr_d[i*WIDTH +: WIDTH]    = hold_q[i*WIDTH +: WIDTH] >> 2;
          end
        end
      end else if (state_q == RUN) begin
        if (last_c) begin
          cnt_d = '0;
          d0_d  = {LANES{INIT}};
          d1_d  = {LANES{INIT}};
        end else begin
          cnt_d = cnt_q + CW'(1);
          // The shift register keeps the next pair at its output end
          for (int unsigned i = 0; i < LANES; i++) begin
            if (MSB_FIRST) begin
              d0_d[i]                = sr_q[i*WIDTH + WIDTH - 1];
              d1_d[i]                = sr_q[i*WIDTH + WIDTH - 2];
              sr_d[i*WIDTH +: WIDTH] = sr_q[i*WIDTH +: WIDTH] << 2;
            end else begin
              d0_d[i]                = sr_q[i*WIDTH];
              d1_d[i]                = sr_q[i*WIDTH + 1];
              sr_d[i*WIDTH +: WIDTH] = sr_q[i*WIDTH +: WIDTH] >> 2;
            end
          end
        end
      end
      if (accept_c) begin
        hold_d      = s_data;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      d0_q        <= {LANES{INIT}};
      d1_q        <= {LANES{INIT}};
      underrun_q  <= 1'b0;
      ucnt_q      <= 8'd0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      underrun_q  <= underrun_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign d0             = d0_q;
  assign d1             = d1_q;
  assign active         = (state_q == RUN);
  assign underrun       = underrun_q & ce;
  assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_oserdes_ddr.sv
// Bench for oserdes_ddr: two instances (8-bit x2 lanes MSB-first, 2-bit x1 lane LSB-first)
// checked every cycle against a word/beat-index model, plus literal expectations.
module tb_oserdes_ddr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, ce;
  logic [15:0] a_data;
  logic        a_valid, a_ready, a_active, a_und;
  logic [1:0]  a_d0, a_d1;
  logic [7:0]  a_ucnt;
  logic [1:0]  b_data;
  logic        b_valid, b_ready, b_active, b_und;
  logic [0:0]  b_d0, b_d1;
  logic [7:0]  b_ucnt;

  oserdes_ddr #(.WIDTH(8), .LANES(2), .INIT(1'b0), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .resetn(resetn), .ce(ce), .s_data(a_data), .s_valid(a_valid),
    .s_ready(a_ready), .d0(a_d0), .d1(a_d1), .active(a_active), .underrun(a_und),
    .underrun_count(a_ucnt));

  oserdes_ddr #(.WIDTH(2), .LANES(1), .INIT(1'b0), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .resetn(resetn), .ce(ce), .s_data(b_data), .s_valid(b_valid),
    .s_ready(b_ready), .d0(b_d0), .d1(b_d1), .active(b_active), .underrun(b_und),
    .underrun_count(b_ucnt));

  // Model: current word plus the beat index being shown, and a one-word hold slot
  typedef struct {
    logic [31:0] hold;
    bit          full;
    logic [31:0] cur;
    int          k;
    bit          run;
    bit          und;
    int          ucnt;
  } model_t;

  model_t ma, mb;
  bit     model_ok = 1'b0;
  int     errs = 0;
  int     checks = 0;

  function automatic model_t mstep(model_t m, int w, bit ce_i, bit rst_i, bit valid,
                                   logic [31:0] data);
    model_t n = m;
    bit load, fin, rdy;
    if (!rst_i) begin
      n.full = 0; n.run = 0; n.k = 0; n.und = 0; n.ucnt = 0;
      return n;
    end
    if (!ce_i) begin
      n.und = 0;
      return n;
    end
    load  = m.full && (!m.run || m.k == w/2 - 1);
    fin   = m.run && (m.k == w/2 - 1) && !m.full;
    rdy   = !m.full || load;
    n.und = fin;
    if (load) begin
      n.cur = m.hold; n.k = 0; n.run = 1; n.full = 0;
    end else if (fin) begin
      n.run = 0; n.k = 0;
    end else if (m.run) begin
      n.k = m.k + 1;
    end
    if (fin && m.ucnt < 255) n.ucnt = m.ucnt + 1;
    if (valid && rdy) begin
      n.hold = data; n.full = 1;
    end
    return n;
  endfunction

  function automatic logic [31:0] mready(model_t m, int w, bit ce_i, bit rst_i);
    return 32'(rst_i && ce_i && (!m.full || !m.run || m.k == w/2 - 1));
  endfunction

  // Bit pair of beat k taken straight from the word by index
  function automatic logic [31:0] mdat(model_t m, int w, int lanes, bit msb, int sec);
    logic [31:0] r = '0;
    int idx;
    if (!m.run) return '0;
    for (int i = 0; i < lanes; i++) begin
      idx  = msb ? (i*w + w - 1 - 2*m.k - sec) : (i*w + 2*m.k + sec);
      r[i] = m.cur[idx];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (!model_ok) return;
    chk("a_d0",     32'(a_d0),     mdat(ma, 8, 2, 1'b1, 0));
    chk("a_d1",     32'(a_d1),     mdat(ma, 8, 2, 1'b1, 1));
    chk("a_active", 32'(a_active), 32'(ma.run));
    chk("a_und",    32'(a_und),    32'(ma.und && ce));
    chk("a_ucnt",   32'(a_ucnt),   32'(ma.ucnt));
    chk("a_ready",  32'(a_ready),  mready(ma, 8, ce, resetn));
    chk("b_d0",     32'(b_d0),     mdat(mb, 2, 1, 1'b0, 0));
    chk("b_d1",     32'(b_d1),     mdat(mb, 2, 1, 1'b0, 1));
    chk("b_active", 32'(b_active), 32'(mb.run));
    chk("b_und",    32'(b_und),    32'(mb.und && ce));
    chk("b_ucnt",   32'(b_ucnt),   32'(mb.ucnt));
    chk("b_ready",  32'(b_ready),  mready(mb, 2, ce, resetn));
  endtask

  // Compare mid-cycle, then advance DUT and model across one rising edge
  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    ma = mstep(ma, 8, ce, resetn, a_valid, 32'(a_data));
    mb = mstep(mb, 2, ce, resetn, b_valid, 32'(b_data));
    if (!resetn) model_ok = 1'b1;
    #1;
  endtask

  task automatic pair_a(input string name, input logic [1:0] e0, input logic [1:0] e1);
    chk({name, "_d0"}, 32'(a_d0), 32'(e0));
    chk({name, "_d1"}, 32'(a_d1), 32'(e1));
  endtask

  logic [15:0] words [3];
  int idx, act_n, und_n, falls;
  bit acc, prev_act;

  initial begin
    words[0] = 16'h1234; words[1] = 16'hA5C3; words[2] = 16'hFF00;
    resetn = 1'b0; ce = 1'b1;
    a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;

    // Reset
    cyc(); cyc();
    chk("rst_d0", 32'(a_d0), 32'h0);
    chk("rst_d1", 32'(a_d1), 32'h0);
    chk("rst_ready", 32'(a_ready), 32'h0);
    chk("rst_ucnt", 32'(a_ucnt), 32'h0);
    resetn = 1'b1;
    #1;
    chk("rel_ready", 32'(a_ready), 32'h1);
    chk("rel_active", 32'(a_active), 32'h0);

    // Single word: lane0 B4, lane1 5A
    a_data = 16'h5AB4; a_valid = 1'b1;
    cyc();
    a_valid = 1'b0;
    cyc(); pair_a("sw_b0", 2'b01, 2'b10);
    cyc(); pair_a("sw_b1", 2'b01, 2'b11);
    cyc(); pair_a("sw_b2", 2'b10, 2'b01);
    cyc(); pair_a("sw_b3", 2'b10, 2'b00);
    cyc();
    pair_a("sw_idle", 2'b00, 2'b00);
    chk("sw_und", 32'(a_und), 32'h1);
    chk("sw_ucnt", 32'(a_ucnt), 32'h1);
    chk("sw_active", 32'(a_active), 32'h0);
    cyc();
    chk("sw_und_off", 32'(a_und), 32'h0);

    // Back-to-back: three words with valid held high
    idx = 0; act_n = 0; und_n = 0; falls = 0; prev_act = 1'b0;
    a_data = words[0]; a_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #1;
      acc = (idx < 3) && a_ready;
      cyc();
      if (acc) begin
        idx++;
        if (idx < 3) a_data = words[idx];
        else a_valid = 1'b0;
      end
      if (a_active) act_n++;
      if (a_und) und_n++;
      if (prev_act && !a_active) falls++;
      prev_act = a_active;
    end
    chk("b2b_accepted", 32'(idx), 32'd3);
    chk("b2b_beats", 32'(act_n), 32'd12);
    chk("b2b_underruns", 32'(und_n), 32'd1);
    chk("b2b_active_falls", 32'(falls), 32'd1);

    // ce stall at beat 1
    a_data = 16'h5AB4; a_valid = 1'b1;
    cyc();
    a_valid = 1'b0;
    cyc();
    cyc(); pair_a("ce_b1", 2'b01, 2'b11);
    ce = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc();
      pair_a("ce_frozen", 2'b01, 2'b11);
      chk("ce_ready", 32'(a_ready), 32'h0);
      chk("ce_und", 32'(a_und), 32'h0);
    end
    ce = 1'b1;
    cyc(); pair_a("ce_b2", 2'b10, 2'b01);
    cyc(); pair_a("ce_b3", 2'b10, 2'b00);
    cyc(); chk("ce_und_end", 32'(a_und), 32'h1);

    // Reset mid-word with an all-ones word waiting in hold
    a_data = 16'h5AB4; a_valid = 1'b1;
    cyc();
    a_data = 16'hFFFF;
    cyc();
    a_valid = 1'b0;
    pair_a("rm_b0", 2'b01, 2'b10);
    chk("rm_hold_full_ready", 32'(a_ready), 32'h0);
    cyc();
    cyc(); pair_a("rm_b2", 2'b10, 2'b01);
    resetn = 1'b0;
    cyc();
    pair_a("rm_init", 2'b00, 2'b00);
    chk("rm_active", 32'(a_active), 32'h0);
    chk("rm_ucnt", 32'(a_ucnt), 32'h0);
    resetn = 1'b1;
    for (int n = 0; n < 8; n++) begin
      cyc();
      pair_a("rm_quiet", 2'b00, 2'b00);
      chk("rm_quiet_active", 32'(a_active), 32'h0);
    end

    // WIDTH=2 LSB-first stream: 01, 10, 11
    b_valid = 1'b1; b_data = 2'b01;
    cyc();
    b_data = 2'b10;
    cyc();
    chk("w2_p0", {30'd0, b_d1, b_d0}, 32'b01);
    b_data = 2'b11;
    cyc();
    chk("w2_p1", {30'd0, b_d1, b_d0}, 32'b10);
    b_valid = 1'b0;
    cyc();
    chk("w2_p2", {30'd0, b_d1, b_d0}, 32'b11);
    cyc();
    chk("w2_und", 32'(b_und), 32'h1);
    chk("w2_ucnt", 32'(b_ucnt), 32'h1);

    // Saturate the underrun counter
    for (int n = 0; n < 300; n++) begin
      b_valid = 1'b1; b_data = 2'($urandom);
      cyc();
      b_valid = 1'b0;
      cyc();
    end
    cyc(); cyc();
    chk("w2_sat", 32'(b_ucnt), 32'd255);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/oserdes_ddr.md
OSERDES_DDR -- requirements
Module: oserdes_ddr

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 8: bits per lane per word; even, 2..32.
REQ-002 The block SHALL have parameter LANES, default 1: independent output lanes sharing one handshake; 1..8.
REQ-003 The block SHALL have parameter INIT, default 1'b0: idle and reset level of every d0/d1 bit.
REQ-004 The block SHALL have parameter MSB_FIRST, default 1: 1 = MSB-first serialisation, 0 = LSB-first.

Ports:
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port ce, input, 1 bit: clock enable; low freezes all state.
REQ-008 The block SHALL have port s_data, input, WIDTH*LANES bits: lane i word = s_data[i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port s_valid, input, 1 bit: s_data valid.
REQ-010 The block SHALL have port s_ready, output, 1 bit: block can accept a word.
REQ-011 The block SHALL have port d0, output, LANES bits: first-half-cycle bit per lane, for the DDR output primitive.
REQ-012 The block SHALL have port d1, output, LANES bits: second-half-cycle bit per lane.
REQ-013 The block SHALL have port active, output, 1 bit: state is RUN.
REQ-014 The block SHALL have port underrun, output, 1 bit: one-cycle pulse when RUN ends because no next word is held.
REQ-015 The block SHALL have port underrun_count, output, 8 bits: saturating count of underrun pulses.

Function
REQ-016 A word SHALL be accepted on a rising edge where resetn=1, ce=1, s_valid=1 and s_ready=1; it is written into a one-entry hold register.
REQ-017 s_ready SHALL be (hold empty OR load occurring this edge) AND resetn AND ce; it SHALL NOT depend on s_valid.
REQ-018 The FSM SHALL have two states, IDLE and RUN; per lane it SHALL hold a WIDTH-bit shift register plus a beat counter 0..WIDTH/2-1.
REQ-019 A load (hold -> shift register, counter=0, state=RUN, hold marked empty unless simultaneously refilled) SHALL occur when hold is full and either (state=IDLE) or (state=RUN and counter=WIDTH/2-1).
REQ-020 In RUN without a load, each ce=1 edge SHALL advance the counter by 1 and shift 2 bits per lane.
REQ-021 RUN, last beat, hold empty SHALL transition to IDLE, assert underrun for exactly one cycle and increment underrun_count (saturate at 255).
REQ-022 Beat k (0-based) with MSB_FIRST=1 SHALL drive d0=word[WIDTH-1-2k] and d1=word[WIDTH-2-2k]; with MSB_FIRST=0, d0=word[2k] and d1=word[2k+1].
REQ-023 d0/d1 SHALL be registered; in IDLE every bit SHALL equal INIT.
REQ-024 Latency SHALL be as follows: word accepted at edge N with state IDLE -> beat 0 visible after edge N+1.
REQ-025 With s_valid held high, consecutive words SHALL stream with no idle beat; throughput is one word per WIDTH/2 cycles (one per cycle for WIDTH=2).
REQ-026 ce=0 SHALL hold every register (outputs, counter, hold, count); underrun SHALL be 0 while ce=0.
REQ-027 All lanes SHALL always be at the same beat; the block has no per-lane handshake.

Reset
REQ-028 On a rising edge with resetn=0, the block SHALL set state=IDLE, hold empty, counter=0, d0=d1={LANES{INIT}}, underrun=0 and underrun_count=0.
REQ-029 While resetn=0, s_ready SHALL be 0.
REQ-030 A reset mid-word or with hold full SHALL discard both words, and the block SHALL resume in IDLE.

Verification
REQ-031 Bench case, reset (WIDTH=8, LANES=2, INIT=0): resetn=0 for 2 cycles -> d0=d1=2'b00, s_ready=0, count=0; after release -> s_ready=1, active=0.
REQ-032 Bench case, single word: lane0=8'hB4, MSB_FIRST=1 -> lane0 (d0,d1) pairs (1,0),(1,1),(0,1),(0,0) on 4 consecutive cycles starting after edge N+1; then IDLE at INIT, underrun pulse, count=1.
REQ-033 Bench case, back-to-back: 3 words with s_valid held high -> 12 consecutive beats, active stays 1, exactly one underrun at the end, s_ready low whenever hold is full and not at the last beat.
REQ-034 Bench case, ce stall: ce=0 for 3 cycles at beat 1 -> d0/d1 and counter frozen, s_ready=0; resume at beat 2 with no lost or repeated pair.
REQ-035 Bench case, reset mid-word: resetn=0 at beat 2 with hold full -> d0/d1=INIT next cycle; no held-word bits are ever emitted.
REQ-036 Bench case, WIDTH=2, MSB_FIRST=0: words 2'b01, 2'b10, 2'b11 on consecutive cycles -> pairs (1,0),(0,1),(1,1) on consecutive cycles; 256 underruns -> count holds at 255.
